// File: rtl/game_flow_controller_if.sv
// Signal bundle between the maze-game flow sequencer and the character/score side.
// The controller takes the slave modport; the character blocks or bench take the master.
interface game_flow_controller_if #(
    parameter int NUM_GHOSTS = 4,
    parameter int SCORE_W    = 18
);
    logic                    start;
    logic                    frame_tick;
    logic [5:0]              pac_xtile;
    logic [5:0]              pac_ytile;
    logic [6*NUM_GHOSTS-1:0] ghost_xtile;
    logic [6*NUM_GHOSTS-1:0] ghost_ytile;
    logic [2*NUM_GHOSTS-1:0] ghost_mode;
    logic                    pellet_eaten;
    logic                    power_eaten;
    logic [2:0]              state;
    logic                    reset_players;
    logic                    pause;
    logic                    frightened;
    logic [NUM_GHOSTS-1:0]   ghost_eat;
    logic [1:0]              eat_chain;
    logic [2:0]              lives;
    logic [7:0]              level;
    logic [SCORE_W-1:0]      score;
    logic                    ghost_anim;
    logic                    pellet_anim;

    modport master (
        output start, frame_tick, pac_xtile, pac_ytile, ghost_xtile, ghost_ytile,
               ghost_mode, pellet_eaten, power_eaten,
        input  state, reset_players, pause, frightened, ghost_eat, eat_chain,
               lives, level, score, ghost_anim, pellet_anim
    );

    modport slave (
        input  start, frame_tick, pac_xtile, pac_ytile, ghost_xtile, ghost_ytile,
               ghost_mode, pellet_eaten, power_eaten,
        output state, reset_players, pause, frightened, ghost_eat, eat_chain,
               lives, level, score, ghost_anim, pellet_anim
    );
endinterface

// File: rtl/game_flow_controller.sv
// Maze-game flow sequencer: phase FSM with frame-tick timers, scoring, lives,
// level progression and sprite animation toggles.
module game_flow_controller #(
    parameter int NUM_GHOSTS       = 4,
    parameter int LIVES            = 3,
    parameter int PELLET_COUNT     = 244,
    parameter int FRIGHT_FRAMES    = 360,
    parameter int EAT_FRAMES       = 60,
    parameter int DEATH_FRAMES     = 90,
    parameter int READY_FRAMES     = 120,
    parameter int CLEAR_FRAMES     = 120,
    parameter int ANIM_DIV         = 8,
    parameter int EXTRA_LIFE_SCORE = 10000,
    parameter int SCORE_W          = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    game_flow_controller_if.slave bus
);
    localparam int TW = 16;
    localparam int PW = 16;
    localparam int AW = SCORE_W + 12;

    localparam logic [TW-1:0] READY_T    = TW'(READY_FRAMES);
    localparam logic [TW-1:0] FRIGHT_T   = TW'(FRIGHT_FRAMES);
    localparam logic [TW-1:0] EAT_T      = TW'(EAT_FRAMES);
    localparam logic [TW-1:0] DEATH_T    = TW'(DEATH_FRAMES);
    localparam logic [TW-1:0] CLEAR_T    = TW'(CLEAR_FRAMES);
    localparam logic [TW-1:0] GANIM_LAST = TW'(ANIM_DIV - 1);
    localparam logic [TW-1:0] PANIM_LAST = TW'(2 * ANIM_DIV - 1);
    localparam logic [PW-1:0] PELLET_INIT = PW'(PELLET_COUNT);
    localparam logic [2:0]    LIVES_INIT  = 3'(LIVES);
    localparam logic [AW-1:0] EXTRA_T     = AW'(EXTRA_LIFE_SCORE);
    localparam logic [AW-1:0] SCORE_MAX   = AW'((64'd1 << SCORE_W) - 64'd1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_EAT   = 3'd3,
        ST_DYING = 3'd4,
        ST_CLEAR = 3'd5,
        ST_OVER  = 3'd6
    } state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [TW-1:0]         fright_q, fright_d;
    logic [1:0]            chain_q, chain_d;
    logic [2:0]            lives_q, lives_d;
    logic [7:0]            level_q, level_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [PW-1:0]         pellets_q, pellets_d;
    logic                  xlife_q, xlife_d;
    logic [NUM_GHOSTS-1:0] ghost_eat_q, ghost_eat_d;
    logic [TW-1:0]         ganim_cnt_q, ganim_cnt_d;
    logic [TW-1:0]         panim_cnt_q, panim_cnt_d;
    logic                  ganim_q, ganim_d;
    logic                  panim_q, panim_d;

    logic                  hostile_hit_s;
    logic                  eat_hit_s;
    logic                  eat_take_s;
    logic [NUM_GHOSTS-1:0] eat_onehot_s;
    logic                  tile_match_s;
    logic                  take_s;
    logic                  timer_done_s;
    logic [TW-1:0]         fright_run_s;
    logic [1:0]            eff_chain_s;
    logic [PW-1:0]         pel_cnt_s;
    logic [PW-1:0]         pellets_left_s;
    logic [AW-1:0]         add_s;
    logic [AW-1:0]         sum_s;
    logic [AW-1:0]         score_sat_s;

    function automatic logic [1:0] chain_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    // Collision decode: any hostile contact, plus the lowest-index frightened contact.
    always_comb begin
        hostile_hit_s = 1'b0;
        eat_hit_s     = 1'b0;
        eat_onehot_s  = {NUM_GHOSTS{1'b0}};
        tile_match_s  = 1'b0;
        take_s        = 1'b0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            tile_match_s    = (bus.ghost_xtile[6*i +: 6] == bus.pac_xtile) &&
                              (bus.ghost_ytile[6*i +: 6] == bus.pac_ytile);
            hostile_hit_s   = hostile_hit_s | (tile_match_s && (bus.ghost_mode[2*i +: 2] == 2'b00));
            take_s          = tile_match_s && (bus.ghost_mode[2*i +: 2] == 2'b01) && !eat_hit_s;
            eat_onehot_s[i] = take_s;
            eat_hit_s       = eat_hit_s | take_s;
        end
    end

    // PLAY datapath: points, saturating score, pellet counter and fright countdown.
    always_comb begin
        timer_done_s   = bus.frame_tick && (timer_q <= TW'(1));
        fright_run_s   = (bus.frame_tick && fright_q != {TW{1'b0}}) ? fright_q - TW'(1) : fright_q;
        eat_take_s     = eat_hit_s && !hostile_hit_s;
        // A power pellet in the same cycle as an eat starts the new fright first.
        eff_chain_s    = bus.power_eaten ? 2'd0 : chain_q;
        pel_cnt_s      = PW'(bus.pellet_eaten) + PW'(bus.power_eaten);
        pellets_left_s = (pellets_q > pel_cnt_s) ? pellets_q - pel_cnt_s : {PW{1'b0}};
        add_s          = (bus.pellet_eaten ? AW'(6'd10) : AW'(6'd0)) +
                         (bus.power_eaten  ? AW'(6'd50) : AW'(6'd0)) +
                         (eat_take_s ? (AW'(8'd200) << eff_chain_s) : AW'(8'd0));
        sum_s          = AW'(score_q) + add_s;
        score_sat_s    = (sum_s > SCORE_MAX) ? SCORE_MAX : sum_s;
    end

    // Phase sequencing and game bookkeeping.
    always_comb begin
        state_d     = state_q;
        timer_d     = (bus.frame_tick && timer_q != {TW{1'b0}}) ? timer_q - TW'(1) : timer_q;
        fright_d    = fright_q;
        chain_d     = chain_q;
        lives_d     = lives_q;
        level_d     = level_q;
        score_d     = score_q;
        pellets_d   = pellets_q;
        xlife_d     = xlife_q;
        ghost_eat_d = {NUM_GHOSTS{1'b0}};
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d   = ST_READY;
                    timer_d   = READY_T;
                    fright_d  = {TW{1'b0}};
                    chain_d   = 2'd0;
                    score_d   = {SCORE_W{1'b0}};
                    lives_d   = LIVES_INIT;
                    level_d   = 8'd1;
                    pellets_d = PELLET_INIT;
                    xlife_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_READY: state_d = timer_done_s ? ST_PLAY : ST_READY;
            ST_PLAY: begin
                fright_d  = bus.power_eaten ? FRIGHT_T : fright_run_s;
                chain_d   = eat_take_s ? chain_inc(eff_chain_s) : eff_chain_s;
                score_d   = score_sat_s[SCORE_W-1:0];
                pellets_d = pellets_left_s;
                if (!xlife_q && score_sat_s >= EXTRA_T) begin
                    xlife_d = 1'b1;
                    lives_d = (lives_q == 3'd7) ? 3'd7 : lives_q + 3'd1;
                end else begin
                    xlife_d = xlife_q;
                end
                if (hostile_hit_s) begin
                    state_d  = ST_DYING;
                    timer_d  = DEATH_T;
                    fright_d = {TW{1'b0}};
                    chain_d  = 2'd0;
                end else if (pellets_q != {PW{1'b0}} && pellets_left_s == {PW{1'b0}}) begin
                    state_d     = ST_CLEAR;
                    timer_d     = CLEAR_T;
                    fright_d    = {TW{1'b0}};
                    chain_d     = 2'd0;
                    ghost_eat_d = eat_onehot_s;
                end else if (eat_take_s) begin
                    state_d     = ST_EAT;
                    timer_d     = EAT_T;
                    ghost_eat_d = eat_onehot_s;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_EAT: state_d = timer_done_s ? ST_PLAY : ST_EAT;
            ST_DYING: begin
                if (timer_done_s) begin
                    if (lives_q <= 3'd1) begin
                        lives_d = 3'd0;
                        state_d = ST_OVER;
                    end else begin
                        lives_d = lives_q - 3'd1;
                        state_d = ST_READY;
                        timer_d = READY_T;
                    end
                end else begin
                    state_d = ST_DYING;
                end
            end
            ST_CLEAR: begin
                if (timer_done_s) begin
                    level_d   = (level_q == 8'd255) ? 8'd255 : level_q + 8'd1;
                    pellets_d = PELLET_INIT;
                    state_d   = ST_READY;
                    timer_d   = READY_T;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Animation dividers: ghost sprite runs only while unpaused, pellet blink outside IDLE.
    always_comb begin
        ganim_cnt_d = ganim_cnt_q;
        ganim_d     = ganim_q;
        panim_cnt_d = panim_cnt_q;
        panim_d     = panim_q;
        if (bus.frame_tick && state_q == ST_PLAY) begin
            ganim_cnt_d = (ganim_cnt_q >= GANIM_LAST) ? {TW{1'b0}} : ganim_cnt_q + TW'(1);
            ganim_d     = (ganim_cnt_q >= GANIM_LAST) ? ~ganim_q : ganim_q;
        end else begin
            ganim_cnt_d = ganim_cnt_q;
        end
        if (bus.frame_tick && state_q != ST_IDLE) begin
            panim_cnt_d = (panim_cnt_q >= PANIM_LAST) ? {TW{1'b0}} : panim_cnt_q + TW'(1);
            panim_d     = (panim_cnt_q >= PANIM_LAST) ? ~panim_q : panim_q;
        end else begin
            panim_cnt_d = panim_cnt_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= {TW{1'b0}};
            fright_q    <= {TW{1'b0}};
            chain_q     <= 2'd0;
            lives_q     <= LIVES_INIT;
            level_q     <= 8'd1;
            score_q     <= {SCORE_W{1'b0}};
            pellets_q   <= PELLET_INIT;
            xlife_q     <= 1'b0;
            ghost_eat_q <= {NUM_GHOSTS{1'b0}};
            ganim_cnt_q <= {TW{1'b0}};
            panim_cnt_q <= {TW{1'b0}};
            ganim_q     <= 1'b0;
            panim_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fright_q    <= fright_d;
            chain_q     <= chain_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            score_q     <= score_d;
            pellets_q   <= pellets_d;
            xlife_q     <= xlife_d;
            ghost_eat_q <= ghost_eat_d;
            ganim_cnt_q <= ganim_cnt_d;
            panim_cnt_q <= panim_cnt_d;
            ganim_q     <= ganim_d;
            panim_q     <= panim_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.reset_players = (state_q == ST_IDLE) || (state_q == ST_READY);
    assign bus.pause         = (state_q != ST_PLAY);
    assign bus.frightened    = (fright_q != {TW{1'b0}});
    assign bus.ghost_eat     = ghost_eat_q;
    assign bus.eat_chain     = chain_q;
    assign bus.lives         = lives_q;
    assign bus.level         = level_q;
    assign bus.score         = score_q;
    assign bus.ghost_anim    = ganim_q;
    assign bus.pellet_anim   = panim_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench: a default-parameter instance for flow/scoring/death, and a small
// instance for level clear, extra life and reset during an eat pause.
module tb_game_flow_controller;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    game_flow_controller_if #(.NUM_GHOSTS(4), .SCORE_W(18)) a ();
    game_flow_controller_if #(.NUM_GHOSTS(2), .SCORE_W(18)) b ();

    game_flow_controller u_a (.clk(clk), .rst(rst_a), .bus(a));

    game_flow_controller #(
        .NUM_GHOSTS(2), .LIVES(2), .PELLET_COUNT(4), .FRIGHT_FRAMES(10),
        .EAT_FRAMES(2), .DEATH_FRAMES(2), .READY_FRAMES(3), .CLEAR_FRAMES(5),
        .ANIM_DIV(2), .EXTRA_LIFE_SCORE(30), .SCORE_W(18)
    ) u_b (.clk(clk), .rst(rst_b), .bus(b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: frame_tick as given, one-cycle pulses dropped afterwards.
    task automatic cyc(input logic tk);
        a.frame_tick = tk;
        b.frame_tick = tk;
        @(negedge clk);
        a.frame_tick = 1'b0;  b.frame_tick = 1'b0;
        a.pellet_eaten = 1'b0; b.pellet_eaten = 1'b0;
        a.power_eaten = 1'b0;  b.power_eaten = 1'b0;
        a.start = 1'b0;        b.start = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
    endtask

    task automatic ghost_a(input int i, input logic [5:0] x, input logic [5:0] y, input logic [1:0] m);
        a.ghost_xtile[6*i +: 6] = x;
        a.ghost_ytile[6*i +: 6] = y;
        a.ghost_mode[2*i +: 2]  = m;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a.start = 1'b0; a.frame_tick = 1'b0; a.pellet_eaten = 1'b0; a.power_eaten = 1'b0;
        b.start = 1'b0; b.frame_tick = 1'b0; b.pellet_eaten = 1'b0; b.power_eaten = 1'b0;
        a.pac_xtile = 6'd10; a.pac_ytile = 6'd20;
        b.pac_xtile = 6'd10; b.pac_ytile = 6'd20;
        a.ghost_xtile = 24'd0; a.ghost_ytile = 24'd0; a.ghost_mode = 8'd0;
        b.ghost_xtile = 12'd0; b.ghost_ytile = 12'd0; b.ghost_mode = 4'd0;
        @(negedge clk);
        cyc(1'b0);
        cyc(1'b0);
        rst_a = 1'b0; rst_b = 1'b0;

        chk("rst_state", 32'(a.state), 32'd0);
        chk("rst_score", 32'(a.score), 32'd0);
        chk("rst_lives", 32'(a.lives), 32'd3);
        chk("rst_level", 32'(a.level), 32'd1);
        chk("rst_fright", 32'(a.frightened), 32'd0);
        chk("rst_chain", 32'(a.eat_chain), 32'd0);
        chk("rst_geat", 32'(a.ghost_eat), 32'd0);
        chk("rst_ganim", 32'(a.ghost_anim), 32'd0);
        chk("rst_panim", 32'(a.pellet_anim), 32'd0);
        chk("rst_resetp", 32'(a.reset_players), 32'd1);
        chk("rst_pause", 32'(a.pause), 32'd1);
        chk("rst_b_lives", 32'(b.lives), 32'd2);

        a.start = 1'b1;
        cyc(1'b0);
        chk("start_ready", 32'(a.state), 32'd1);
        tick(119);
        chk("ready_119", 32'(a.state), 32'd1);
        chk("ready_resetp", 32'(a.reset_players), 32'd1);
        cyc(1'b1);
        chk("ready_120_play", 32'(a.state), 32'd2);
        chk("play_resetp", 32'(a.reset_players), 32'd0);
        chk("play_pause", 32'(a.pause), 32'd0);
        cyc(1'b0);
        chk("panim_120", 32'(a.pellet_anim), 32'd1);
        chk("ganim_ready", 32'(a.ghost_anim), 32'd0);

        for (int i = 0; i < 3; i++) begin
            a.pellet_eaten = 1'b1;
            cyc(1'b0);
        end
        a.power_eaten = 1'b1;
        cyc(1'b0);
        chk("score_80", 32'(a.score), 32'd80);
        chk("fright_on", 32'(a.frightened), 32'd1);
        tick(359);
        chk("fright_359", 32'(a.frightened), 32'd1);
        tick(1);
        chk("fright_360", 32'(a.frightened), 32'd0);
        chk("ganim_360", 32'(a.ghost_anim), 32'd1);
        chk("panim_480", 32'(a.pellet_anim), 32'd0);

        a.power_eaten = 1'b1;
        cyc(1'b0);
        chk("score_130", 32'(a.score), 32'd130);
        ghost_a(1, 6'd10, 6'd20, 2'b01);
        ghost_a(2, 6'd10, 6'd20, 2'b01);
        cyc(1'b0);
        chk("eat1_state", 32'(a.state), 32'd3);
        chk("eat1_geat", 32'(a.ghost_eat), 32'b0010);
        chk("eat1_score", 32'(a.score), 32'd330);
        chk("eat1_chain", 32'(a.eat_chain), 32'd1);
        ghost_a(1, 6'd10, 6'd20, 2'b10);
        cyc(1'b0);
        chk("eat1_pulse", 32'(a.ghost_eat), 32'd0);
        tick(59);
        chk("eatp_59", 32'(a.state), 32'd3);
        cyc(1'b1);
        chk("eatp_60", 32'(a.state), 32'd2);
        cyc(1'b0);
        chk("eat2_state", 32'(a.state), 32'd3);
        chk("eat2_geat", 32'(a.ghost_eat), 32'b0100);
        chk("eat2_score", 32'(a.score), 32'd730);
        ghost_a(2, 6'd10, 6'd20, 2'b10);
        ghost_a(0, 6'd10, 6'd20, 2'b01);
        ghost_a(3, 6'd10, 6'd20, 2'b01);
        tick(59);
        cyc(1'b1);
        cyc(1'b0);
        chk("eat3_geat", 32'(a.ghost_eat), 32'b0001);
        chk("eat3_score", 32'(a.score), 32'd1530);
        ghost_a(0, 6'd10, 6'd20, 2'b10);
        tick(59);
        cyc(1'b1);
        cyc(1'b0);
        chk("eat4_geat", 32'(a.ghost_eat), 32'b1000);
        chk("eat4_score", 32'(a.score), 32'd3130);
        chk("eat4_chain_sat", 32'(a.eat_chain), 32'd3);
        ghost_a(3, 6'd10, 6'd20, 2'b10);
        tick(59);
        cyc(1'b1);
        chk("eat4_back_play", 32'(a.state), 32'd2);
        tick(359);
        chk("fright_frozen", 32'(a.frightened), 32'd1);
        tick(1);
        chk("fright_end", 32'(a.frightened), 32'd0);

        ghost_a(0, 6'd10, 6'd20, 2'b00);
        ghost_a(1, 6'd0, 6'd0, 2'b00);
        ghost_a(2, 6'd0, 6'd0, 2'b00);
        ghost_a(3, 6'd10, 6'd20, 2'b01);
        a.pellet_eaten = 1'b1;
        cyc(1'b0);
        chk("die_state", 32'(a.state), 32'd4);
        chk("die_geat", 32'(a.ghost_eat), 32'd0);
        chk("die_score", 32'(a.score), 32'd3140);
        chk("die_chain", 32'(a.eat_chain), 32'd0);
        ghost_a(0, 6'd0, 6'd0, 2'b00);
        ghost_a(3, 6'd0, 6'd0, 2'b00);
        tick(89);
        chk("die_89", 32'(a.state), 32'd4);
        cyc(1'b1);
        chk("die_ready", 32'(a.state), 32'd1);
        chk("die_lives2", 32'(a.lives), 32'd2);
        tick(120);
        chk("die_play2", 32'(a.state), 32'd2);
        ghost_a(0, 6'd10, 6'd20, 2'b00);
        cyc(1'b0);
        ghost_a(0, 6'd0, 6'd0, 2'b00);
        tick(90);
        chk("die2_lives1", 32'(a.lives), 32'd1);
        tick(120);
        ghost_a(0, 6'd10, 6'd20, 2'b00);
        cyc(1'b0);
        ghost_a(0, 6'd0, 6'd0, 2'b00);
        tick(90);
        chk("over_state", 32'(a.state), 32'd6);
        chk("over_lives", 32'(a.lives), 32'd0);
        chk("over_resetp", 32'(a.reset_players), 32'd0);
        chk("over_score", 32'(a.score), 32'd3140);
        a.start = 1'b1;
        cyc(1'b0);
        chk("restart_state", 32'(a.state), 32'd1);
        chk("restart_score", 32'(a.score), 32'd0);
        chk("restart_lives", 32'(a.lives), 32'd3);

        b.start = 1'b1;
        cyc(1'b0);
        tick(3);
        chk("b_play", 32'(b.state), 32'd2);
        for (int i = 0; i < 2; i++) begin
            b.pellet_eaten = 1'b1;
            cyc(1'b0);
        end
        chk("b_score20", 32'(b.score), 32'd20);
        chk("b_lives_pre", 32'(b.lives), 32'd2);
        b.pellet_eaten = 1'b1;
        cyc(1'b0);
        chk("b_xlife", 32'(b.lives), 32'd3);
        b.pellet_eaten = 1'b1;
        cyc(1'b0);
        chk("b_clear", 32'(b.state), 32'd5);
        chk("b_score40", 32'(b.score), 32'd40);
        tick(4);
        chk("b_clear_4", 32'(b.state), 32'd5);
        cyc(1'b1);
        chk("b_clear_ready", 32'(b.state), 32'd1);
        chk("b_level2", 32'(b.level), 32'd2);
        tick(3);
        for (int i = 0; i < 3; i++) begin
            b.pellet_eaten = 1'b1;
            cyc(1'b0);
        end
        chk("b_score70", 32'(b.score), 32'd70);
        chk("b_xlife_once", 32'(b.lives), 32'd3);
        chk("b_reload_play", 32'(b.state), 32'd2);
        b.pellet_eaten = 1'b1;
        cyc(1'b0);
        chk("b_clear2", 32'(b.state), 32'd5);
        tick(5);
        tick(3);
        b.power_eaten = 1'b1;
        cyc(1'b0);
        b.ghost_xtile[5:0] = 6'd10;
        b.ghost_ytile[5:0] = 6'd20;
        b.ghost_mode[1:0]  = 2'b01;
        cyc(1'b0);
        chk("b_eat_state", 32'(b.state), 32'd3);
        chk("b_eat_geat", 32'(b.ghost_eat), 32'b01);
        chk("b_eat_score", 32'(b.score), 32'd330);
        rst_b = 1'b1;
        cyc(1'b0);
        rst_b = 1'b0;
        chk("b_rst_state", 32'(b.state), 32'd0);
        chk("b_rst_score", 32'(b.score), 32'd0);
        chk("b_rst_lives", 32'(b.lives), 32'd2);
        chk("b_rst_level", 32'(b.level), 32'd1);
        chk("b_rst_fright", 32'(b.frightened), 32'd0);
        chk("b_rst_chain", 32'(b.eat_chain), 32'd0);
        chk("b_rst_geat", 32'(b.ghost_eat), 32'd0);
        chk("b_rst_ganim", 32'(b.ghost_anim), 32'd0);
        chk("b_rst_panim", 32'(b.pellet_anim), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
